mc_maindec: RTL
===============

# mc_maindec

Multicycle main control unit for the MIPS core: a state machine that sequences each instruction through fetch, decode, execute, memory and write-back, in place of the single-cycle combinational main decoder. It sits between the instruction register and the shared-memory multicycle datapath. It drives every datapath enable and mux select, waits on a memory-ready handshake, and flags illegal opcodes. It also keeps a retired-instruction counter for the performance bench.

## Interface
- MEM_WAIT, 1: 1 = memory states hold until `memready`; 0 = `memready` ignored, one cycle per memory access.
- CNT_W, 32: width of the retired-instruction counter.
- HAS_JR, 1: 1 = funct 001000 under op 000000 decodes as JR; 0 = it is an R-type.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0].
- isnop  in  1  instruction register == 32'h0.
- memready  in  1  memory completed the current access this cycle.
- pcwrite, pcwritecond, irwrite, regwrite, memread, memwrite  out  1 each  datapath strobes.
- iord, memtoreg, regdst, alusrca, signext, shiftl16, link, nez  out  1 each  datapath selects.
- alusrcb  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2.
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs (JR).
- aluop  out  2  00 add, 01 sub, 10 funct field, 11 or.
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode.
- state  out  4  current state, for debug.
- instret  out  CNT_W  retired-instruction count.

## Operation
- States and transitions:
  - FETCH → DECODE
  - DECODE → MEMADR (LW/SW), RTEXE (R-type), BRANCH (BEQ/BNE), IEXE (ADDI/ADDIU/ORI/LUI), JUMP (J), JAL, JR, or FETCH (NOP or illegal)
  - MEMADR → MEMRD (LW) or MEMWR (SW)
  - MEMRD → MEMWB → FETCH
  - MEMWR → FETCH
  - RTEXE → ALUWB → FETCH
  - IEXE → IWB → FETCH
  - BRANCH, JUMP, JAL, JR → FETCH
- SLTI/SLTIU (001010/001011) are illegal.
- Outputs are Moore: a function of `state` only, except that the gated strobes also use `memready`. The `op`-dependent selects are latched into a class register in DECODE.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite and pcwrite are asserted only in the cycle `memready` is high (always, if MEM_WAIT=0).
- DECODE: alusrca=0, alusrcb=11, signext=1, aluop=00. This precomputes the branch target.
- MEMADR: alusrca=1, alusrcb=10, signext=1, aluop=00.
- MEMRD: memread=1, iord=1, held until ready. MEMWB: regwrite=1, memtoreg=1, regdst=0.
- MEMWR: memwrite=1, iord=1, held until ready. memwrite stays high for every held cycle.
- RTEXE: alusrca=1, alusrcb=00, aluop=10. ALUWB: regwrite=1, regdst=1.
- IEXE: alusrca=1, alusrcb=10.
  - ADDI/ADDIU: signext=1, aluop=00.
  - ORI: signext=0, aluop=11.
  - LUI: shiftl16=1, aluop=11.
- IWB: regwrite=1, regdst=0.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsrc=01. nez=1 for BNE, 0 for BEQ.
- JUMP: pcwrite=1, pcsrc=10.
- JAL: pcwrite=1, pcsrc=10, regwrite=1, link=1.
- JR: pcwrite=1, pcsrc=11.
- Every output not listed for a state is 0.
- instret increments by 1 on each transition into FETCH from any state other than FETCH, including NOP and illegal. It wraps modulo 2^CNT_W with no saturation.

## Timing
- Cycles per instruction, with zero wait states:
  - LW: 5
  - SW, R-type, I-type: 4
  - BEQ, BNE, J, JAL, JR: 3
  - NOP, illegal: 2
- With MEM_WAIT=1, each low-`memready` cycle in FETCH, MEMRD or MEMWR adds one cycle.
- `memready` is sampled at the rising edge. A state leaves on the edge where `memready`=1. `memready` high in any non-memory state is ignored.
- Reset: while `reset` is high, every strobe is forced to 0 combinationally (memread, memwrite, irwrite, pcwrite, pcwritecond, regwrite). On the edge, state=FETCH, instret=0 and the class register is cleared. This holds mid-instruction too: a pending MEMWR is abandoned with no further memwrite.
- illegal is high only during the single DECODE cycle and is 0 in reset.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - the state enum (4-bit encoding, FETCH=0)
  - the opcode and funct constants
  - the alusrcb, pcsrc and aluop encodings
- One sub-module, `mc_opclass`: combinational op/funct/isnop → instruction class plus illegal. HAS_JR is passed down to it.
- The FSM, output decode and counter live in `mc_maindec`.

## Test plan
- Reset then LW (op 100011), memready tied 1 → states 0→DECODE→MEMADR→MEMRD→MEMWB→FETCH in 5 cycles, with regwrite=1 and memtoreg=1 only in MEMWB, and instret=1.
- SW with memready low for 3 cycles in MEMWR → memwrite high for 4 consecutive cycles, then FETCH; total 7 cycles.
- BNE (op 000101), then R-type ADD, then JAL → pcwritecond=1 with nez=1 in BRANCH; regdst=1 in ALUWB; link=1, regwrite=1 and pcsrc=10 in JAL; instret=3.
- op 001010 → illegal pulses for exactly 1 cycle, FETCH on the next edge, instret increments; isnop=1 → 2-cycle NOP with no regwrite.
- Reset asserted in MEMWR while memready=0 → memwrite drops to 0 in the same cycle; after the edge, state=FETCH and instret=0.
- CNT_W=4, 17 NOPs → instret reads 1 (wrap). HAS_JR=0 with funct 001000 → RTEXE path, not JR.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, instruction-class and datapath-select encodings for the MIPS control path
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEXE,
    S_ALUWB, S_IEXE, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR
  } state_t;
  typedef enum logic [3:0] {
    C_NONE, C_LW, C_SW, C_RT, C_BEQ, C_BNE, C_ADDI, C_ORI, C_LUI,
    C_J, C_JAL, C_JR, C_NOP, C_ILL
  } cls_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;
endpackage

// File: rtl/mc_opclass.sv
// mc_opclass: classifies op/funct/isnop into an instruction class; anything unsupported is illegal
module mc_opclass import mips_ctrl_pkg::*; #(
  parameter int HAS_JR = 1
) (
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       isnop,
  output cls_t       cls,
  output logic       illegal
);
  always_comb begin
    cls = C_ILL;
    if (isnop) cls = C_NOP;
    else
      case (op)
        OP_RTYPE:          cls = (HAS_JR != 0 && funct == FN_JR) ? C_JR : C_RT;
        OP_LW:             cls = C_LW;
        OP_SW:             cls = C_SW;
        OP_BEQ:            cls = C_BEQ;
        OP_BNE:            cls = C_BNE;
        OP_ADDI, OP_ADDIU: cls = C_ADDI;
        OP_ORI:            cls = C_ORI;
        OP_LUI:            cls = C_LUI;
        OP_J:              cls = C_J;
        OP_JAL:            cls = C_JAL;
        default:           cls = C_ILL;
      endcase
  end
  assign illegal = cls == C_ILL;
endmodule

// File: rtl/mc_maindec.sv
// mc_maindec: multicycle MIPS main control FSM with memory-ready handshake and retired-instruction counter
module mc_maindec import mips_ctrl_pkg::*; #(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 32,
  parameter int HAS_JR   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             isnop,
  input  logic             memready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             irwrite,
  output logic             regwrite,
  output logic             memread,
  output logic             memwrite,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic             alusrca,
  output logic             signext,
  output logic             shiftl16,
  output logic             link,
  output logic             nez,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [1:0]       aluop,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);
  state_t           state_q, state_d;
  cls_t             cls_q, cls_d, dec_cls;
  logic             dec_ill, rdy;
  logic [CNT_W-1:0] instret_q, instret_d;

  mc_opclass #(.HAS_JR(HAS_JR)) u_opclass (
    .op(op), .funct(funct), .isnop(isnop), .cls(dec_cls), .illegal(dec_ill)
  );

  assign rdy = MEM_WAIT == 0 || memready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE:
        case (dec_cls)
          C_LW, C_SW:           state_d = S_MEMADR;
          C_RT:                 state_d = S_RTEXE;
          C_BEQ, C_BNE:         state_d = S_BRANCH;
          C_ADDI, C_ORI, C_LUI: state_d = S_IEXE;
          C_J:                  state_d = S_JUMP;
          C_JAL:                state_d = S_JAL;
          C_JR:                 state_d = S_JR;
          default:              state_d = S_FETCH;
        endcase
      S_MEMADR: state_d = cls_q == C_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = rdy ? S_FETCH : S_MEMWR;
      S_RTEXE:  state_d = S_ALUWB;
      S_IEXE:   state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
    cls_d     = state_q == S_DECODE ? dec_cls : cls_q;
    instret_d = instret_q + CNT_W'(state_d == S_FETCH && state_q != S_FETCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      instret_q <= instret_d;
    end
  end

  // Strobes are killed combinationally by reset so an in-flight store never completes
  assign memread     = !reset && state_q inside {S_FETCH, S_MEMRD};
  assign memwrite    = !reset && state_q == S_MEMWR;
  assign irwrite     = !reset && state_q == S_FETCH && rdy;
  assign pcwrite     = !reset && ((state_q == S_FETCH && rdy) || state_q inside {S_JUMP, S_JAL, S_JR});
  assign pcwritecond = !reset && state_q == S_BRANCH;
  assign regwrite    = !reset && state_q inside {S_MEMWB, S_ALUWB, S_IWB, S_JAL};
  assign iord        = state_q inside {S_MEMRD, S_MEMWR};
  assign memtoreg    = state_q == S_MEMWB;
  assign regdst      = state_q == S_ALUWB;
  assign alusrca     = state_q inside {S_MEMADR, S_RTEXE, S_IEXE, S_BRANCH};
  assign signext     = state_q inside {S_DECODE, S_MEMADR} || (state_q == S_IEXE && cls_q == C_ADDI);
  assign shiftl16    = state_q == S_IEXE && cls_q == C_LUI;
  assign link        = state_q == S_JAL;
  assign nez         = state_q == S_BRANCH && cls_q == C_BNE;
  assign alusrcb     = state_q == S_FETCH ? SRCB_4 : state_q == S_DECODE ? SRCB_IMM2 :
                       state_q inside {S_MEMADR, S_IEXE} ? SRCB_IMM : SRCB_B;
  assign pcsrc       = state_q == S_BRANCH ? PC_ALUOUT : state_q inside {S_JUMP, S_JAL} ? PC_JUMP :
                       state_q == S_JR ? PC_RS : PC_ALU;
  assign aluop       = state_q == S_RTEXE ? ALU_FUNCT : state_q == S_BRANCH ? ALU_SUB :
                       (state_q == S_IEXE && cls_q inside {C_ORI, C_LUI}) ? ALU_OR : ALU_ADD;
  assign illegal     = !reset && state_q == S_DECODE && dec_ill;
  assign state       = state_q;
  assign instret     = instret_q;
endmodule
